mult_exhaustive_checker: RTL and testbench

- Self-checking evaluation stage wrapped around a combinational (or pipelined) candidate multiplier produced by the architecture search.
- Upstream side: drives every operand pair (A,B) into the multiplier under test.
- Downstream side: consumes the product P, compares it against a golden A*B, counts mismatches, and captures the first failing vector.
- Result (pass flag, error count) feeds the search reward logic; one start pulse triggers one full sweep.

---
 rtl/mult_exhaustive_checker_if.sv | 11 +
 rtl/mult_exhaustive_checker.sv | 183 ++++++++++++++++++
 tb/tb_mult_exhaustive_checker.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_exhaustive_checker_if.sv
// Operand/product bundle between the exhaustive checker and the multiplier under test.
interface mult_exhaustive_checker_if #(
   parameter int unsigned W = 2
);
   logic [W-1:0]   dut_a;
   logic [W-1:0]   dut_b;
   logic [2*W-1:0] dut_p;

   modport master (output dut_a, output dut_b, input dut_p);
   modport slave  (input dut_a, input dut_b, output dut_p);
endinterface

// File: rtl/mult_exhaustive_checker.sv
// Sweeps every (A,B) operand pair through a candidate multiplier and scores its products
// against a golden A*B, counting mismatches and capturing the first failing vector.
module mult_exhaustive_checker #(
   parameter int unsigned W   = 2,
   parameter int unsigned LAT = 0
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      start_i,
   mult_exhaustive_checker_if.master dut_io,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      pass_o,
   output logic [2*W:0]              err_count_o,
   output logic                      fail_valid_o,
   output logic [W-1:0]              fail_a_o,
   output logic [W-1:0]              fail_b_o,
   output logic [2*W-1:0]            fail_p_o
);
   localparam int unsigned PW = 2 * W;
   localparam logic [PW:0] ErrMax = {1'b1, {PW{1'b0}}};

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   idx_q, idx_d;
   logic [W-1:0]    a_q, a_d, b_q, b_d;
   logic [2:0]      drain_q, drain_d;
   logic [PW:0]     err_q, err_d;
   logic            fv_q, fv_d, pass_q, pass_d;
   logic [W-1:0]    fa_q, fa_d, fb_q, fb_d;
   logic [PW-1:0]   fp_q, fp_d;

   logic            cmp_valid;
   logic [W-1:0]    cmp_a, cmp_b;
   logic [PW-1:0]   cmp_exp;

   // Expectation pipe: compare stage sees vector k exactly LAT cycles after it is driven.
   if (LAT == 0) begin : g_no_pipe
      always_comb begin
         cmp_valid = (state_q == StRun);
         cmp_a     = a_q;
         cmp_b     = b_q;
         cmp_exp   = PW'(a_q) * PW'(b_q);
      end
   end else begin : g_pipe
      logic [LAT-1:0] v_q;
      logic [W-1:0]   pa_q [LAT];
      logic [W-1:0]   pb_q [LAT];
      logic [PW-1:0]  pe_q [LAT];

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            v_q <= '0;
            for (int i = 0; i < int'(LAT); i++) begin
               pa_q[i] <= '0;
               pb_q[i] <= '0;
               pe_q[i] <= '0;
            end
         end else begin
            v_q[0]  <= (state_q == StRun);
            pa_q[0] <= a_q;
            pb_q[0] <= b_q;
            pe_q[0] <= PW'(a_q) * PW'(b_q);
            for (int i = 1; i < int'(LAT); i++) begin
               v_q[i]  <= v_q[i-1];
               pa_q[i] <= pa_q[i-1];
               pb_q[i] <= pb_q[i-1];
               pe_q[i] <= pe_q[i-1];
            end
         end
      end

      assign cmp_valid = v_q[LAT-1];
      assign cmp_a     = pa_q[LAT-1];
      assign cmp_b     = pb_q[LAT-1];
      assign cmp_exp   = pe_q[LAT-1];
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      drain_d = drain_q;
      err_d   = err_q;
      fv_d    = fv_q;
      fa_d    = fa_q;
      fb_d    = fb_q;
      fp_d    = fp_q;
      pass_d  = pass_q;

      if (cmp_valid && (dut_io.dut_p != cmp_exp)) begin
         if (err_q != ErrMax) err_d = err_q + (PW+1)'(1);
         if (!fv_q) begin
            fv_d = 1'b1;
            fa_d = cmp_a;
            fb_d = cmp_b;
            fp_d = dut_io.dut_p;
         end
      end

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StRun;
               idx_d   = '0;
               a_d     = '0;
               b_d     = '0;
               err_d   = '0;
               fv_d    = 1'b0;
               fa_d    = '0;
               fb_d    = '0;
               fp_d    = '0;
               pass_d  = 1'b0;
            end
         end
         StRun: begin
            if (idx_q == '1) begin
               drain_d = '0;
               if (LAT == 0) begin
                  state_d = StDone;
                  pass_d  = (err_d == '0);
               end else begin
                  state_d = StDrain;
               end
            end else begin
               idx_d      = idx_q + PW'(1);
               {b_d, a_d} = idx_d;
            end
         end
         StDrain: begin
            if (drain_q == 3'(LAT - 1)) begin
               state_d = StDone;
               pass_d  = (err_d == '0);
            end else begin
               drain_d = drain_q + 3'd1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         drain_q <= '0;
         err_q   <= '0;
         fv_q    <= 1'b0;
         fa_q    <= '0;
         fb_q    <= '0;
         fp_q    <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         drain_q <= drain_d;
         err_q   <= err_d;
         fv_q    <= fv_d;
         fa_q    <= fa_d;
         fb_q    <= fb_d;
         fp_q    <= fp_d;
         pass_q  <= pass_d;
      end
   end

   assign dut_io.dut_a = a_q;
   assign dut_io.dut_b = b_q;
   assign busy_o       = (state_q == StRun) || (state_q == StDrain);
   assign done_o       = (state_q == StDone);
   assign pass_o       = pass_q;
   assign err_count_o  = err_q;
   assign fail_valid_o = fv_q;
   assign fail_a_o     = fa_q;
   assign fail_b_o     = fb_q;
   assign fail_p_o     = fp_q;
endmodule

// File: tb/tb_mult_exhaustive_checker.sv
// Directed bench: five checker instances around ideal and faulty multiplier models.
module tb_mult_exhaustive_checker;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [4:0] start;
   int checks   = 0;
   int failures = 0;

   logic busy0, done0, pass0, fv0, busy1, done1, pass1, fv1;
   logic busy2, done2, pass2, fv2, busy3, done3, pass3, fv3;
   logic busy4, done4, pass4, fv4;
   logic [4:0] err0, err1, err2, err3;
   logic [1:0] fa0, fb0, fa1, fb1, fa2, fb2, fa3, fb3;
   logic [3:0] fp0, fp1, fp2, fp3;
   logic [6:0] err4;
   logic [2:0] fa4, fb4;
   logic [5:0] fp4;

   mult_exhaustive_checker_if #(.W(2)) if0 ();
   mult_exhaustive_checker_if #(.W(2)) if1 ();
   mult_exhaustive_checker_if #(.W(2)) if2 ();
   mult_exhaustive_checker_if #(.W(2)) if3 ();
   mult_exhaustive_checker_if #(.W(3)) if4 ();

   // Multiplier models: ideal, P[0] stuck-at-1, two 2-stage ideal, 1-stage with 7*7 forced to 0.
   logic [3:0] p2_s1, p2_s2, p3_s1, p3_s2;
   logic [5:0] p4_s1;
   assign if0.dut_p = 4'(if0.dut_a) * 4'(if0.dut_b);
   assign if1.dut_p = (4'(if1.dut_a) * 4'(if1.dut_b)) | 4'd1;
   assign if2.dut_p = p2_s2;
   assign if3.dut_p = p3_s2;
   assign if4.dut_p = p4_s1;
   always_ff @(posedge clk) begin
      p2_s1 <= 4'(if2.dut_a) * 4'(if2.dut_b);
      p2_s2 <= p2_s1;
      p3_s1 <= 4'(if3.dut_a) * 4'(if3.dut_b);
      p3_s2 <= p3_s1;
      p4_s1 <= (if4.dut_a == 3'd7 && if4.dut_b == 3'd7) ? 6'd0 : 6'(if4.dut_a) * 6'(if4.dut_b);
   end

   mult_exhaustive_checker #(.W(2), .LAT(0)) u0 (
      .clk_i(clk), .rst_i(rst), .start_i(start[0]), .dut_io(if0), .busy_o(busy0),
      .done_o(done0), .pass_o(pass0), .err_count_o(err0), .fail_valid_o(fv0),
      .fail_a_o(fa0), .fail_b_o(fb0), .fail_p_o(fp0));
   mult_exhaustive_checker #(.W(2), .LAT(0)) u1 (
      .clk_i(clk), .rst_i(rst), .start_i(start[1]), .dut_io(if1), .busy_o(busy1),
      .done_o(done1), .pass_o(pass1), .err_count_o(err1), .fail_valid_o(fv1),
      .fail_a_o(fa1), .fail_b_o(fb1), .fail_p_o(fp1));
   mult_exhaustive_checker #(.W(2), .LAT(2)) u2 (
      .clk_i(clk), .rst_i(rst), .start_i(start[2]), .dut_io(if2), .busy_o(busy2),
      .done_o(done2), .pass_o(pass2), .err_count_o(err2), .fail_valid_o(fv2),
      .fail_a_o(fa2), .fail_b_o(fb2), .fail_p_o(fp2));
   mult_exhaustive_checker #(.W(2), .LAT(0)) u3 (
      .clk_i(clk), .rst_i(rst), .start_i(start[3]), .dut_io(if3), .busy_o(busy3),
      .done_o(done3), .pass_o(pass3), .err_count_o(err3), .fail_valid_o(fv3),
      .fail_a_o(fa3), .fail_b_o(fb3), .fail_p_o(fp3));
   mult_exhaustive_checker #(.W(3), .LAT(1)) u4 (
      .clk_i(clk), .rst_i(rst), .start_i(start[4]), .dut_io(if4), .busy_o(busy4),
      .done_o(done4), .pass_o(pass4), .err_count_o(err4), .fail_valid_o(fv4),
      .fail_a_o(fa4), .fail_b_o(fb4), .fail_p_o(fp4));

   // Leaves the bench just after the start edge (edge 0); the next negedge lies in cycle 1.
   task automatic pulse_start(input logic [4:0] m);
      @(negedge clk);
      start = m;
      @(posedge clk);
      #1;
      start = '0;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy0, done0, pass0, fv0} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags got %b want 0000", {busy0, done0, pass0, fv0});
      end
      checks++;
      if ({err0, fa0, fb0, fp0} !== 13'd0) begin
         failures++;
         $display("FAIL reset_regs got err=%0d fa=%0d fb=%0d fp=%0d want 0", err0, fa0, fb0, fp0);
      end
      checks++;
      if ({if0.dut_a, if0.dut_b, if4.dut_a, if4.dut_b} !== 10'd0) begin
         failures++;
         $display("FAIL reset_operands got a0=%0d b0=%0d a4=%0d b4=%0d want 0",
                  if0.dut_a, if0.dut_b, if4.dut_a, if4.dut_b);
      end
      rst = 1'b0;
   endtask

   task automatic test_sweep_ideal();
      int done_cyc = -1;
      int done_cnt = 0;
      int vec_bad  = 0;
      pulse_start(5'b00001);
      for (int c = 1; c <= 22; c++) begin
         @(negedge clk);
         if (c <= 16 && (if0.dut_a !== 2'((c - 1) % 4) || if0.dut_b !== 2'((c - 1) / 4)
                         || busy0 !== 1'b1)) vec_bad++;
         if (c == 17 && busy0 !== 1'b0) vec_bad++;
         if (done0) begin
            done_cnt++;
            done_cyc = c;
         end
      end
      checks++;
      if (vec_bad != 0) begin
         failures++;
         $display("FAIL sweep_sequence got %0d bad cycles want 0", vec_bad);
      end
      checks++;
      if (done_cyc != 17 || done_cnt != 1) begin
         failures++;
         $display("FAIL sweep_done got cycle=%0d count=%0d want cycle=17 count=1", done_cyc, done_cnt);
      end
      checks++;
      if (pass0 !== 1'b1 || err0 !== 5'd0 || fv0 !== 1'b0) begin
         failures++;
         $display("FAIL sweep_result got pass=%0b err=%0d fv=%0b want 1 0 0", pass0, err0, fv0);
      end
   endtask

   task automatic test_stuck_bit();
      int done_cyc = -1;
      pulse_start(5'b00010);
      for (int c = 1; c <= 22; c++) begin
         @(negedge clk);
         if (done1) done_cyc = c;
      end
      checks++;
      if (done_cyc != 17 || err1 !== 5'd12 || pass1 !== 1'b0) begin
         failures++;
         $display("FAIL stuck_count got done=%0d err=%0d pass=%0b want 17 12 0", done_cyc, err1, pass1);
      end
      checks++;
      if (fv1 !== 1'b1 || fa1 !== 2'd0 || fb1 !== 2'd0 || fp1 !== 4'd1) begin
         failures++;
         $display("FAIL stuck_capture got fv=%0b a=%0d b=%0d p=%0d want 1 0 0 1", fv1, fa1, fb1, fp1);
      end
   endtask

   task automatic test_latency();
      int done2_cyc = -1;
      int done3_cyc = -1;
      pulse_start(5'b01100);
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         if (done2) done2_cyc = c;
         if (done3) done3_cyc = c;
      end
      checks++;
      if (done2_cyc != 19 || pass2 !== 1'b1 || err2 !== 5'd0) begin
         failures++;
         $display("FAIL lat2_match got done=%0d pass=%0b err=%0d want 19 1 0", done2_cyc, pass2, err2);
      end
      checks++;
      if (done3_cyc != 17 || pass3 !== 1'b0 || err3 == 5'd0) begin
         failures++;
         $display("FAIL lat0_mismatch got done=%0d pass=%0b err=%0d want 17 0 >0",
                  done3_cyc, pass3, err3);
      end
   endtask

   task automatic test_start_ignored();
      int done_cnt  = 0;
      int vec_bad   = 0;
      logic pass_c1 = 1'b1;
      logic busy_18 = 1'b1;
      pulse_start(5'b00001);
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         start[0] = (c == 5 || c == 17);
         if (c == 1) pass_c1 = pass0;
         if (c == 18) busy_18 = busy0;
         if (c <= 16 && (if0.dut_a !== 2'((c - 1) % 4) || if0.dut_b !== 2'((c - 1) / 4)))
            vec_bad++;
         if (done0) done_cnt++;
      end
      start = '0;
      checks++;
      if (pass_c1 !== 1'b0) begin
         failures++;
         $display("FAIL start_clears_pass got %0b want 0", pass_c1);
      end
      checks++;
      if (vec_bad != 0 || done_cnt != 1) begin
         failures++;
         $display("FAIL repulse_sweep got bad=%0d done_count=%0d want 0 1", vec_bad, done_cnt);
      end
      checks++;
      if (busy_18 !== 1'b0 || busy0 !== 1'b0 || pass0 !== 1'b1) begin
         failures++;
         $display("FAIL repulse_idle got busy18=%0b busy=%0b pass=%0b want 0 0 1",
                  busy_18, busy0, pass0);
      end
   endtask

   task automatic test_single_fault_w3();
      int done_cyc = -1;
      pulse_start(5'b10000);
      for (int c = 1; c <= 75; c++) begin
         @(negedge clk);
         if (done4) done_cyc = c;
      end
      checks++;
      if (done_cyc != 66 || err4 !== 7'd1 || pass4 !== 1'b0) begin
         failures++;
         $display("FAIL w3_count got done=%0d err=%0d pass=%0b want 66 1 0", done_cyc, err4, pass4);
      end
      checks++;
      if (fv4 !== 1'b1 || fa4 !== 3'd7 || fb4 !== 3'd7 || fp4 !== 6'd0) begin
         failures++;
         $display("FAIL w3_capture got fv=%0b a=%0d b=%0d p=%0d want 1 7 7 0", fv4, fa4, fb4, fp4);
      end
   endtask

   task automatic test_reset_mid_sweep();
      int done_cnt = 0;
      int done_cyc = -1;
      pulse_start(5'b00010);
      repeat (8) @(negedge clk);
      checks++;
      if (err1 !== 5'd6) begin
         failures++;
         $display("FAIL midreset_pre got err=%0d want 6", err1);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (busy1 !== 1'b0 || err1 !== 5'd0 || fv1 !== 1'b0 || done1 !== 1'b0) begin
         failures++;
         $display("FAIL midreset_post got busy=%0b err=%0d fv=%0b done=%0b want 0 0 0 0",
                  busy1, err1, fv1, done1);
      end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done1) done_cnt++;
      end
      checks++;
      if (done_cnt != 0) begin
         failures++;
         $display("FAIL midreset_nodone got %0d done pulses want 0", done_cnt);
      end
      pulse_start(5'b00010);
      for (int c = 1; c <= 22; c++) begin
         @(negedge clk);
         if (done1) done_cyc = c;
      end
      checks++;
      if (done_cyc != 17 || err1 !== 5'd12 || fv1 !== 1'b1 || fp1 !== 4'd1) begin
         failures++;
         $display("FAIL midreset_rerun got done=%0d err=%0d fv=%0b p=%0d want 17 12 1 1",
                  done_cyc, err1, fv1, fp1);
      end
   endtask

   initial begin
      test_reset();
      test_sweep_ideal();
      test_stuck_bit();
      test_latency();
      test_start_ignored();
      test_single_fault_w3();
      test_reset_mid_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
